dvp_pattern_tx: RTL and testbench
=================================

// Module: dvp_pattern_tx
// PURPOSE
//  Synthesizable DVP (OV5640-style) camera transmitter: the sending end of the interface
//  camera_capture receives. Drives vsync/href/8-bit data with RGB565 test patterns, two
//  bytes per pixel, high byte first. Replaces cmos1_* pins in bring-up to exercise the
//  capture -> DDR -> HDMI path without a sensor. clk stands in for the sensor pclk.
// PARAMETERS
//  H_ACTIVE   640  pixels per line (even, >=8)
//  V_ACTIVE   480  active lines per frame (>=1)
//  H_BLANK    160  href-low cycles after each active line (>=1)
//  VSYNC_LEN  16   cycles vsync high at frame start (>=1)
//  V_BACK     32   blank cycles between vsync fall and first href (>=1)
//  V_FRONT    8    blank cycles after last line's H_BLANK, before frame_done (>=1)
// PORTS
//  clk          in   1   pixel clock; all logic on posedge
//  rst          in   1   synchronous, active-high reset
//  enable       in   1   level; start frames / keep streaming
//  pattern_sel  in   2   0 bars, 1 ramp, 2 frame id, 3 checker; sampled at frame start
//  dvp_vsync    out  1   frame sync, active high
//  dvp_href     out  1   line valid, active high
//  dvp_data     out  8   pixel byte; 8'h00 whenever dvp_href low
//  frame_done   out  1   one-cycle pulse at end of each frame
//  frame_cnt    out  8   completed-frame count, wraps 255->0
//  busy         out  1   high in every state except IDLE
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE; vsync/href/data/frame_done/busy = 0;
//    frame_cnt = 0; internal x/y/byte-phase/pixel counters = 0. Reset mid-frame aborts;
//    outputs are 0 from the first edge with rst high.
//  - FSM: IDLE -> VSYNC -> VBACK -> LINE -> HBLANK -> (LINE | VFRONT) -> DONE -> (VSYNC|IDLE)
//    IDLE:   enable sampled 1 -> VSYNC next cycle; latch pattern_sel.
//    VSYNC:  dvp_vsync=1 for exactly VSYNC_LEN cycles.
//    VBACK:  V_BACK cycles, all outputs low.
//    LINE:   dvp_href=1 for exactly 2*H_ACTIVE cycles; byte phase 0 = pix[15:8],
//            phase 1 = pix[7:0]; x increments after phase 1.
//    HBLANK: H_BLANK cycles href low; then y+1; if y==V_ACTIVE-1 -> VFRONT else LINE.
//    VFRONT: V_FRONT cycles low.  DONE: 1 cycle, frame_done=1, frame_cnt+1.
//    DONE -> VSYNC if enable==1 in that cycle (pattern_sel re-latched), else IDLE.
//  - Frame length = VSYNC_LEN+V_BACK+V_ACTIVE*(2*H_ACTIVE+H_BLANK)+V_FRONT+1 cycles.
//  - enable dropping mid-frame does NOT truncate; frame completes, then IDLE.
//  - pattern_sel changes mid-frame ignored until next frame start.
//  - Patterns (pix, 16-bit RGB565), x in [0,H_ACTIVE), y in [0,V_ACTIVE):
//    0 bars: bar=(x*8)/H_ACTIVE -> FFFF,FFE0,07FF,07E0,F81F,F800,001F,0000.
//    1 ramp: 16-bit pixel index, 0 at frame start, +1 per pixel, wraps FFFF->0000.
//    2 frame id: {8'hA5, frame_cnt} (value at frame start) for every pixel.
//    3 checker: (x[3]^y[3]) ? FFFF : 0000.
//  - frame_done and frame_cnt update in the same cycle; busy low only in IDLE.
// TESTING (H_ACTIVE=8,V_ACTIVE=4,H_BLANK=4,VSYNC_LEN=3,V_BACK=5,V_FRONT=2; frame=91 cycles)
//  - Reset/idle: rst high 2 cycles, enable=0 -> all outputs 0 for 100 cycles, busy=0.
//  - Timing: enable=1 -> vsync high 3 cycles, 5 low, 4 href bursts of 16 cycles separated
//    by 4 low; frame_done 1-cycle pulse 91 cycles after VSYNC entry; frame_cnt=1.
//  - Ramp: sel=1 -> bytes 00,00,00,01,...,00,1F over frame; data=00 when href low.
//  - Bars: sel=0 -> each line FF FF FF E0 07 FF 07 E0 F8 1F F8 00 00 1F 00 00.
//  - Stop/re-latch: drop enable and set sel=2 mid-frame 1 -> frame 1 completes unchanged,
//    then IDLE; re-enable -> frame 2 pixels all A5 01; 256 frames -> frame_cnt wraps to 0.
//  - Reset mid-line (cycle 20 of frame) -> next edge outputs 0, FSM IDLE, frame_cnt=0.

Source files
------------

// File: rtl/dvp_pattern_tx.sv
// rtl/dvp_pattern_tx.sv - DVP camera transmitter driving RGB565 test patterns, two bytes per pixel.
module dvp_pattern_tx #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int H_BLANK   = 160,
  parameter int VSYNC_LEN = 16,
  parameter int V_BACK    = 32,
  parameter int V_FRONT   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       dvp_vsync,
  output logic       dvp_href,
  output logic [7:0] dvp_data,
  output logic       frame_done,
  output logic [7:0] frame_cnt,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_VSYNC, S_VBACK, S_LINE, S_HBLANK, S_VFRONT, S_DONE
  } state_t;

  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [15:0] x, x_n;
  logic [15:0] y, y_n;
  logic [15:0] pix_idx, pix_idx_n;
  logic        phase, phase_n;
  logic [1:0]  sel, sel_n;
  logic [7:0]  fid, fid_n;
  logic [7:0]  frame_cnt_n;
  logic        start;
  logic [2:0]  bar_n;
  logic [15:0] pix_n;
  logic [7:0]  data_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      x          <= '0;
      y          <= '0;
      pix_idx    <= '0;
      phase      <= 1'b0;
      sel        <= '0;
      fid        <= '0;
      frame_cnt  <= '0;
      dvp_vsync  <= 1'b0;
      dvp_href   <= 1'b0;
      dvp_data   <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      x          <= x_n;
      y          <= y_n;
      pix_idx    <= pix_idx_n;
      phase      <= phase_n;
      sel        <= sel_n;
      fid        <= fid_n;
      frame_cnt  <= frame_cnt_n;
      dvp_vsync  <= (state_n == S_VSYNC);
      dvp_href   <= (state_n == S_LINE);
      dvp_data   <= data_n;
      frame_done <= (state_n == S_DONE);
      busy       <= (state_n != S_IDLE);
    end
  end

  // Outputs are registered from the next-state values so they line up with the state itself.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    x_n         = x;
    y_n         = y;
    pix_idx_n   = pix_idx;
    phase_n     = phase;
    sel_n       = sel;
    fid_n       = fid;
    frame_cnt_n = frame_cnt;
    start       = 1'b0;

    case (state)
      S_IDLE: begin
        if (enable) start = 1'b1;
      end
      S_VSYNC: begin
        if (cnt == 16'(VSYNC_LEN - 1)) begin
          state_n = S_VBACK;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_VBACK: begin
        if (cnt == 16'(V_BACK - 1)) begin
          state_n = S_LINE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_LINE: begin
        phase_n = ~phase;
        if (phase) begin
          pix_idx_n = pix_idx + 16'd1;
          if (x == 16'(H_ACTIVE - 1)) begin
            x_n     = '0;
            state_n = S_HBLANK;
            cnt_n   = '0;
          end else begin
            x_n = x + 16'd1;
          end
        end
      end
      S_HBLANK: begin
        if (cnt == 16'(H_BLANK - 1)) begin
          cnt_n = '0;
          if (y == 16'(V_ACTIVE - 1)) begin
            state_n = S_VFRONT;
          end else begin
            y_n     = y + 16'd1;
            state_n = S_LINE;
          end
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_VFRONT: begin
        if (cnt == 16'(V_FRONT - 1)) begin
          state_n     = S_DONE;
          cnt_n       = '0;
          frame_cnt_n = frame_cnt + 8'd1;
        end else begin
          cnt_n = cnt + 16'd1;
        end
      end
      S_DONE: begin
        if (enable) start = 1'b1;
        else        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Frame start: pattern select and frame id are frozen for the whole frame.
    if (start) begin
      state_n   = S_VSYNC;
      cnt_n     = '0;
      x_n       = '0;
      y_n       = '0;
      pix_idx_n = '0;
      phase_n   = 1'b0;
      sel_n     = pattern_sel;
      fid_n     = frame_cnt_n;
    end
  end

  always_comb begin
    bar_n = 3'((32'(x_n) * 32'd8) / 32'(H_ACTIVE));
    pix_n = 16'h0000;
    case (sel_n)
      2'd0: begin
        case (bar_n)
          3'd0:    pix_n = 16'hFFFF;
          3'd1:    pix_n = 16'hFFE0;
          3'd2:    pix_n = 16'h07FF;
          3'd3:    pix_n = 16'h07E0;
          3'd4:    pix_n = 16'hF81F;
          3'd5:    pix_n = 16'hF800;
          3'd6:    pix_n = 16'h001F;
          default: pix_n = 16'h0000;
        endcase
      end
      2'd1:    pix_n = pix_idx_n;
      2'd2:    pix_n = {8'hA5, fid_n};
      default: pix_n = (x_n[3] ^ y_n[3]) ? 16'hFFFF : 16'h0000;
    endcase
    data_n = 8'h00;
    if (state_n == S_LINE) data_n = phase_n ? pix_n[7:0] : pix_n[15:8];
  end

endmodule

// File: tb/tb_dvp_pattern_tx.sv
// tb/tb_dvp_pattern_tx.sv - directed self-checking bench for dvp_pattern_tx on a small 8x4 frame.
module tb_dvp_pattern_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [1:0] pattern_sel = 2'd0;
  logic       dvp_vsync, dvp_href, frame_done, busy;
  logic [7:0] dvp_data, frame_cnt;
  logic [19:0] outv;

  int errors = 0;
  int checks = 0;
  int nz, tmo, t;

  dvp_pattern_tx #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .VSYNC_LEN(3), .V_BACK(5), .V_FRONT(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .dvp_vsync(dvp_vsync), .dvp_href(dvp_href), .dvp_data(dvp_data),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  assign outv = {busy, frame_cnt, dvp_vsync, dvp_href, dvp_data, frame_done};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] bar_color(input int x);
    case (x)
      0: return 16'hFFFF;
      1: return 16'hFFE0;
      2: return 16'h07FF;
      3: return 16'h07E0;
      4: return 16'hF81F;
      5: return 16'hF800;
      6: return 16'h001F;
      default: return 16'h0000;
    endcase
  endfunction

  // Expected {busy, frame_cnt, vsync, href, data, frame_done} at cycle k after frame start.
  // Layout: k 0..2 vsync, 3..7 back porch, 8..87 four lines of 16 bytes + 4 blank, 88..89 front, 90 done.
  function automatic logic [19:0] model(input int mode, input logic [7:0] fc0, input int k);
    logic vs, hr, dn;
    logic [7:0] d, fc;
    logic [15:0] pix;
    int r, x, ln;
    vs = (k < 3);
    hr = 1'b0;
    d = 8'h00;
    pix = 16'h0000;
    dn = (k == 90);
    fc = dn ? fc0 + 8'd1 : fc0;
    if (k >= 8 && k < 88) begin
      r = k - 8;
      if ((r % 20) < 16) begin
        hr = 1'b1;
        x = (r % 20) / 2;
        ln = r / 20;
        case (mode)
          0: pix = bar_color(x);
          1: pix = 16'(ln * 8 + x);
          2: pix = {8'hA5, fc0};
          default: pix = 16'h0000;
        endcase
        d = ((r % 2) == 1) ? pix[7:0] : pix[15:8];
      end
    end
    return {1'b1, fc, vs, hr, d, dn};
  endfunction

  task automatic run_frame(input string tag, input int mode, input logic [7:0] fc0,
                           input int change_at, input logic en_new, input logic [1:0] sel_new);
    for (int k = 0; k < 91; k++) begin
      @(negedge clk);
      chk($sformatf("%s k=%0d", tag, k), {12'd0, outv}, {12'd0, model(mode, fc0, k)});
      if (k == change_at) begin
        enable = en_new;
        pattern_sel = sel_new;
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outs", {12'd0, outv}, 32'd0);
    rst = 1'b0;
    nz = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (outv !== 20'd0) nz++;
    end
    chk("idle_quiet_cycles", nz, 0);

    // Ramp; enable drops early but the frame must complete.
    pattern_sel = 2'd1;
    enable = 1'b1;
    run_frame("ramp", 1, 8'd0, 10, 1'b0, 2'd1);
    @(negedge clk);
    chk("ramp_then_idle", {12'd0, outv}, {12'd0, 1'b0, 8'd1, 11'd0});

    // Bars; select changes mid-frame and must be ignored.
    pattern_sel = 2'd0;
    enable = 1'b1;
    run_frame("bars", 0, 8'd1, 40, 1'b0, 2'd2);
    @(negedge clk);
    chk("bars_then_idle", {12'd0, outv}, {12'd0, 1'b0, 8'd2, 11'd0});

    enable = 1'b1;
    run_frame("fid", 2, 8'd2, 10, 1'b1, 2'd3);
    // Back-to-back frames: checker, then ramp re-latched at the DONE cycle.
    run_frame("checker", 3, 8'd3, 80, 1'b1, 2'd1);
    run_frame("ramp2", 1, 8'd4, 5, 1'b0, 2'd1);
    @(negedge clk);
    chk("ramp2_then_idle", {12'd0, outv}, {12'd0, 1'b0, 8'd5, 11'd0});

    pattern_sel = 2'd2;
    enable = 1'b1;
    tmo = 0;
    for (int n = 1; n <= 251; n++) begin
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!frame_done && t < 200);
      if (t >= 200) tmo++;
      if (n == 250) chk("wrap_255", 32'(frame_cnt), 32'd255);
    end
    chk("wrap_timeouts", tmo, 0);
    chk("wrap_0", 32'(frame_cnt), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    chk("wrap_then_idle", {12'd0, outv}, 32'd0);

    // Get frame_cnt nonzero, then reset in the middle of line 0.
    enable = 1'b1;
    pattern_sel = 2'd1;
    run_frame("pre_rst", 1, 8'd0, 200, 1'b1, 2'd1);
    for (int k = 0; k <= 20; k++) @(negedge clk);
    chk("midline_href", {12'd0, outv}, {12'd0, 1'b1, 8'd1, 1'b0, 1'b1, 8'h00, 1'b0});
    rst = 1'b1;
    @(negedge clk);
    chk("midline_reset", {12'd0, outv}, 32'd0);
    enable = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_reset_idle", {12'd0, outv}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
